// File: rtl/vlg_vend_pkg.sv
// Shared FSM state encoding, coin values and coin-sum helper for the vending/change-return path.
package vlg_vend_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_VEND    = 2'd1,
    ST_CHANGE  = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  localparam int COIN_1 = 1;
  localparam int COIN_2 = 2;
  localparam int COIN_5 = 5;

  // Simultaneous coins are summed; worst case 1+2+5 = 8 fits in 4 bits.
  function automatic logic [3:0] coin_value(input logic c1, input logic c2, input logic c5);
    logic [3:0] v;
    v = '0;
    if (c1) v = v + 4'(COIN_1);
    if (c2) v = v + 4'(COIN_2);
    if (c5) v = v + 4'(COIN_5);
    return v;
  endfunction

endpackage

// File: rtl/vlg_pulse_spacer.sv
// Loadable down-counter that spaces actuator pulses; expired is high once the count reaches 0.
// Load takes effect on the next edge; tick decrements and holds at 0; no backpressure.
module vlg_pulse_spacer #(
  parameter int RET_GAP = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic load,
  input  logic tick,
  output logic expired
);

  localparam int GW = (RET_GAP > 1) ? $clog2(RET_GAP) : 1;
  localparam logic [GW-1:0] LOAD_VAL = GW'(RET_GAP - 1);

  logic [GW-1:0] cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/vlg_change_dispenser.sv
// Coin-credit vending controller with greedy 2/1-yuan change return; all outputs registered,
// vend one cycle after the final coin; coins arriving while busy are refused and flagged via o_reject.
module vlg_change_dispenser
  import vlg_vend_pkg::*;
#(
  parameter int PRICE   = 6,
  parameter int RET_GAP = 4,
  parameter int CW      = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_1yuan,
  input  logic          i_2yuan,
  input  logic          i_5yuan,
  output logic          o_done,
  output logic          o_ret_1yuan,
  output logic          o_ret_2yuan,
  output logic          o_busy,
  output logic          o_reject,
  output logic [CW-1:0] o_credit
);

  state_t        state, state_nxt;
  logic [CW-1:0] credit_nxt;
  logic [CW-1:0] sum;
  logic [2:0]    change, change_nxt;
  logic [3:0]    coin;
  logic          gap_load, gap_tick, gap_expired;
  logic          done_nxt, ret1_nxt, ret2_nxt, busy_nxt, reject_nxt;

  assign coin = coin_value(i_1yuan, i_2yuan, i_5yuan);
  assign sum  = o_credit + CW'(coin);

  vlg_pulse_spacer #(
    .RET_GAP (RET_GAP)
  ) u_spacer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .load    (gap_load),
    .tick    (gap_tick),
    .expired (gap_expired)
  );

  always_comb begin
    state_nxt  = state;
    credit_nxt = o_credit;
    change_nxt = change;
    gap_load   = 1'b0;
    gap_tick   = 1'b0;
    case (state)
      ST_COLLECT: begin
        if ((coin != 4'd0) && (sum >= CW'(PRICE))) begin
          credit_nxt = '0;
          change_nxt = 3'(sum - CW'(PRICE));
          state_nxt  = ST_VEND;
        end else begin
          credit_nxt = sum;
        end
      end
      ST_VEND: begin
        state_nxt = (change != 3'd0) ? ST_CHANGE : ST_COLLECT;
      end
      ST_CHANGE: begin
        change_nxt = (change >= 3'd2) ? (change - 3'd2) : (change - 3'd1);
        gap_load   = 1'b1;
        state_nxt  = ST_GAP;
      end
      ST_GAP: begin
        if (gap_expired) begin
          state_nxt = (change != 3'd0) ? ST_CHANGE : ST_COLLECT;
        end else begin
          gap_tick = 1'b1;
        end
      end
      default: state_nxt = ST_COLLECT;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state they describe.
  always_comb begin
    done_nxt   = (state_nxt == ST_VEND);
    busy_nxt   = (state_nxt != ST_COLLECT);
    ret2_nxt   = (state_nxt == ST_CHANGE) && (change_nxt >= 3'd2);
    ret1_nxt   = (state_nxt == ST_CHANGE) && (change_nxt == 3'd1);
    reject_nxt = (state != ST_COLLECT) && (coin != 4'd0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= ST_COLLECT;
      change      <= '0;
      o_credit    <= '0;
      o_done      <= 1'b0;
      o_busy      <= 1'b0;
      o_ret_1yuan <= 1'b0;
      o_ret_2yuan <= 1'b0;
      o_reject    <= 1'b0;
    end else begin
      state       <= state_nxt;
      change      <= change_nxt;
      o_credit    <= credit_nxt;
      o_done      <= done_nxt;
      o_busy      <= busy_nxt;
      o_ret_1yuan <= ret1_nxt;
      o_ret_2yuan <= ret2_nxt;
      o_reject    <= reject_nxt;
    end
  end

endmodule
